// File: rtl/ps2_keyboard_pkg.sv
// Shared constants for the PS/2 keyboard receiver: Hack key codes, scan-code prefixes, FSM states.
package ps2_keyboard_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [7:0] KEY_NEWLINE   = 8'd128;
    localparam logic [7:0] KEY_BACKSPACE = 8'd129;
    localparam logic [7:0] KEY_LEFT      = 8'd130;
    localparam logic [7:0] KEY_UP        = 8'd131;
    localparam logic [7:0] KEY_RIGHT     = 8'd132;
    localparam logic [7:0] KEY_DOWN      = 8'd133;
    localparam logic [7:0] KEY_HOME      = 8'd134;
    localparam logic [7:0] KEY_END       = 8'd135;
    localparam logic [7:0] KEY_PGUP      = 8'd136;
    localparam logic [7:0] KEY_PGDN      = 8'd137;
    localparam logic [7:0] KEY_INSERT    = 8'd138;
    localparam logic [7:0] KEY_DELETE    = 8'd139;
    localparam logic [7:0] KEY_ESC       = 8'd140;
    localparam logic [7:0] KEY_F1        = 8'd141;
    localparam logic [7:0] KEY_F2        = 8'd142;
    localparam logic [7:0] KEY_F3        = 8'd143;
    localparam logic [7:0] KEY_F4        = 8'd144;
    localparam logic [7:0] KEY_F5        = 8'd145;
    localparam logic [7:0] KEY_F6        = 8'd146;
    localparam logic [7:0] KEY_F7        = 8'd147;
    localparam logic [7:0] KEY_F8        = 8'd148;
    localparam logic [7:0] KEY_F9        = 8'd149;
    localparam logic [7:0] KEY_F10       = 8'd150;
    localparam logic [7:0] KEY_F11       = 8'd151;
    localparam logic [7:0] KEY_F12       = 8'd152;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} rx_state_e;

    // PS/2 uses odd parity across the data byte and the parity bit.
    function automatic logic odd_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_keymap.sv
// Combinational scan-code set 2 to Hack key-code lookup.
// Extended (E0-prefixed) codes are decoded only when PS2_EXTENDED_EN is defined.
module ps2_keymap
    import ps2_keyboard_pkg::*;
(
    input  logic [7:0] code,
    input  logic       ext,
    output logic [7:0] key
);

    always_comb begin
        key = 8'd0;
        if (ext) begin
`ifdef PS2_EXTENDED_EN
            case (code)
                8'h6B: key = KEY_LEFT;
                8'h75: key = KEY_UP;
                8'h74: key = KEY_RIGHT;
                8'h72: key = KEY_DOWN;
                8'h6C: key = KEY_HOME;
                8'h69: key = KEY_END;
                8'h7D: key = KEY_PGUP;
                8'h7A: key = KEY_PGDN;
                8'h70: key = KEY_INSERT;
                8'h71: key = KEY_DELETE;
                default: key = 8'd0;
            endcase
`endif
        end else begin
            case (code)
                8'h1C: key = 8'd65;  8'h32: key = 8'd66;  8'h21: key = 8'd67;
                8'h23: key = 8'd68;  8'h24: key = 8'd69;  8'h2B: key = 8'd70;
                8'h34: key = 8'd71;  8'h33: key = 8'd72;  8'h43: key = 8'd73;
                8'h3B: key = 8'd74;  8'h42: key = 8'd75;  8'h4B: key = 8'd76;
                8'h3A: key = 8'd77;  8'h31: key = 8'd78;  8'h44: key = 8'd79;
                8'h4D: key = 8'd80;  8'h15: key = 8'd81;  8'h2D: key = 8'd82;
                8'h1B: key = 8'd83;  8'h2C: key = 8'd84;  8'h3C: key = 8'd85;
                8'h2A: key = 8'd86;  8'h1D: key = 8'd87;  8'h22: key = 8'd88;
                8'h35: key = 8'd89;  8'h1A: key = 8'd90;
                8'h45: key = 8'd48;  8'h16: key = 8'd49;  8'h1E: key = 8'd50;
                8'h26: key = 8'd51;  8'h25: key = 8'd52;  8'h2E: key = 8'd53;
                8'h36: key = 8'd54;  8'h3D: key = 8'd55;  8'h3E: key = 8'd56;
                8'h46: key = 8'd57;
                8'h29: key = 8'd32;
                8'h5A: key = KEY_NEWLINE;
                8'h66: key = KEY_BACKSPACE;
                8'h76: key = KEY_ESC;
                8'h05: key = KEY_F1;   8'h06: key = KEY_F2;   8'h04: key = KEY_F3;
                8'h0C: key = KEY_F4;   8'h03: key = KEY_F5;   8'h0B: key = KEY_F6;
                8'h83: key = KEY_F7;   8'h0A: key = KEY_F8;   8'h01: key = KEY_F9;
                8'h09: key = KEY_F10;  8'h78: key = KEY_F11;  8'h07: key = KEY_F12;
                default: key = 8'd0;
            endcase
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver driving the Hack keyboard word with the currently held key.
// Define PS2_EXTENDED_EN to decode E0-prefixed navigation keys; otherwise they are skipped.
module ps2_keyboard
    import ps2_keyboard_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] out,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]    clk_sync, dat_sync, clk_hist;
    logic          fall, dat_s;
    rx_state_e     state_q, state_d;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_q;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit, rx_done, rx_vld, rx_bad;
    logic          brk_q, map_ext, drop;
    logic [7:0]    map_key, key_q;

    // Synchronizers and clock history idle high so reset never fakes an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_hist <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            clk_hist <= {clk_hist[0], clk_sync[1]};
        end
    end

    assign dat_s   = dat_sync[1];
    assign fall    = ~clk_sync[1] & clk_hist[0] & clk_hist[1];
    assign tmo_hit = (state_q != ST_IDLE) && !fall && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign rx_done = fall && (state_q == ST_STOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (tmo_hit) begin
            state_d = ST_IDLE;
        end else if (fall) begin
            case (state_q)
                ST_IDLE:   if (!dat_s) state_d = ST_DATA;
                ST_DATA:   if (bit_cnt == 3'd7) state_d = ST_PARITY;
                ST_PARITY: state_d = ST_STOP;
                ST_STOP:   state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 3'd0;
            shreg   <= 8'd0;
            par_q   <= 1'b0;
            tmo_cnt <= '0;
            rx_vld  <= 1'b0;
            rx_bad  <= 1'b0;
        end else begin
            rx_vld  <= rx_done & dat_s & odd_ok(shreg, par_q);
            rx_bad  <= rx_done & ~(dat_s & odd_ok(shreg, par_q));
            tmo_cnt <= (state_q == ST_IDLE || fall) ? '0 : tmo_cnt + 1'b1;
            if (tmo_hit) begin
                shreg <= 8'd0;
            end else if (fall) begin
                case (state_q)
                    ST_IDLE:   bit_cnt <= 3'd0;
                    ST_DATA: begin
                        shreg   <= {dat_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    ST_PARITY: par_q <= dat_s;
                    default:   ;
                endcase
            end
        end
    end

    ps2_keymap u_keymap (
        .code (shreg),
        .ext  (map_ext),
        .key  (map_key)
    );

    // E0 arms the flag, F0 leaves it alone, any other accepted byte clears it.
`ifdef PS2_EXTENDED_EN
    logic ext_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          ext_q <= 1'b0;
        else if (rx_vld && shreg != PS2_BRK) ext_q <= (shreg == PS2_EXT);
    end
    assign map_ext = ext_q;
    assign drop    = 1'b0;
`else
    logic skip_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          skip_q <= 1'b0;
        else if (rx_vld && shreg != PS2_BRK) skip_q <= (shreg == PS2_EXT);
    end
    assign map_ext = 1'b0;
    assign drop    = skip_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q     <= 8'd0;
            brk_q     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= rx_bad;
            if (rx_vld) begin
                if (shreg == PS2_BRK) begin
                    brk_q <= 1'b1;
                end else if (shreg != PS2_EXT) begin
                    brk_q <= 1'b0;
                    if (!drop) begin
                        if (!brk_q) begin
                            if (map_key != 8'd0) key_q <= map_key;
                        end else if (map_key == key_q) begin
                            key_q <= 8'd0;
                        end
                    end
                end
            end
        end
    end

    assign out = {8'h00, key_q};

endmodule

// File: tb/tb_ps2_keyboard.sv
// Randomized self-checking bench for ps2_keyboard against a held-key reference model.
module tb_ps2_keyboard;

    localparam int TMO = 1600;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] out;
    logic        frame_err;

    ps2_keyboard #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .out       (out),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: lookup tables plus held-key / prefix rules.
    logic [7:0] map_n [256];
    logic [7:0] map_e [256];
    logic [7:0] known [$];
    logic [7:0] m_out = 8'd0;
    bit         m_brk = 1'b0;
    bit         m_ext = 1'b0;
    int         exp_err = 0;

    logic [7:0] let_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] dig_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] fn_sc  [12] = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B, 8'h83, 8'h0A, 8'h01,
                                8'h09, 8'h78, 8'h07};
    logic [7:0] ext_sc [10] = '{8'h6B, 8'h75, 8'h74, 8'h72, 8'h6C, 8'h69, 8'h7D, 8'h7A, 8'h70, 8'h71};

    task automatic init_maps();
        for (int i = 0; i < 256; i++) begin
            map_n[i] = 8'd0;
            map_e[i] = 8'd0;
        end
        for (int i = 0; i < 26; i++) map_n[let_sc[i]] = 8'(65 + i);
        for (int i = 0; i < 10; i++) map_n[dig_sc[i]] = 8'(48 + i);
        for (int i = 0; i < 12; i++) map_n[fn_sc[i]]  = 8'(141 + i);
        map_n[8'h29] = 8'd32;
        map_n[8'h5A] = 8'd128;
        map_n[8'h66] = 8'd129;
        map_n[8'h76] = 8'd140;
        for (int i = 0; i < 10; i++) map_e[ext_sc[i]] = 8'(130 + i);
        for (int i = 0; i < 256; i++) if (map_n[i] != 8'd0) known.push_back(8'(i));
        for (int i = 0; i < 10; i++) known.push_back(ext_sc[i]);
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] k;
        bit         skip;
        if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            skip = 1'b0;
`ifdef PS2_EXTENDED_EN
            k = m_ext ? map_e[b] : map_n[b];
`else
            k = map_n[b];
            skip = m_ext;
`endif
            if (!skip) begin
                if (!m_brk && k != 8'd0) m_out = k;
                else if (m_brk && k == m_out) m_out = 8'd0;
            end
            m_brk = 1'b0;
            m_ext = 1'b0;
        end
    endtask

    int err_pulses = 0;
    int err_long   = 0;
    bit err_prev   = 1'b0;
    always @(negedge clk) begin
        if (frame_err && !err_prev) err_pulses++;
        if (frame_err && err_prev)  err_long++;
        err_prev = frame_err;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ps2_bit(input bit b);
        ps2_data = b;
        wait_cyc($urandom_range(4, 8));
        ps2_clk = 1'b0;
        wait_cyc($urandom_range(4, 8));
        ps2_clk = 1'b1;
    endtask

    // Sends one 11-bit frame; lat = clk cycles from the stop-bit falling edge until out matches the model.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, output int lat);
        bit par;
        par = ~(^b) ^ bad_par;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        if (bad_par || bad_stop) exp_err++;
        else model_byte(b);
        ps2_data = !bad_stop;
        wait_cyc($urandom_range(4, 8));
        ps2_clk = 1'b0;
        lat = 0;
        while (lat < 10 && out !== {8'h00, m_out}) begin
            @(posedge clk);
            #1;
            lat++;
        end
        wait_cyc($urandom_range(4, 8));
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(6);
    endtask

    task automatic send_good(input logic [7:0] b);
        int lat;
        send_frame(b, 1'b0, 1'b0, lat);
    endtask

    initial begin
        int lat;
        int r;
        logic [7:0] b;
        bit bp, bs;

        init_maps();
        wait_cyc(4);
        check("rst_out", out, 32'h0);
        check("rst_err", frame_err, 32'h0);
        rst_n = 1'b1;
        wait_cyc(4);

        send_frame(8'h1C, 1'b0, 1'b0, lat);
        check("make_A_out", out, 32'h0041);
        check("make_A_lat_le5", (lat <= 5) ? 1 : 0, 32'h1);
        check("make_A_err", err_pulses, 32'h0);

        send_good(8'hF0); send_good(8'h1C);
        check("break_A", out, 32'h0);
        send_good(8'h1C); send_good(8'hF0); send_good(8'h32);
        check("break_B_not_held", out, 32'h0041);

        send_frame(8'h1C, 1'b1, 1'b0, lat);
        check("bad_par_out", out, 32'h0041);
        check("bad_par_err", err_pulses, 32'h1);
        check("bad_par_width", err_long, 32'h0);

        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
        wait_cyc(TMO + 10);
        send_good(8'h5A);
        check("timeout_enter", out, 32'h0080);
        check("timeout_err", err_pulses, 32'h1);

        send_good(8'hE0); send_good(8'h75);
`ifdef PS2_EXTENDED_EN
        check("ext_up", out, 32'h0083);
`else
        check("ext_up_ignored", out, 32'h0080);
`endif
        send_good(8'hE0); send_good(8'hF0); send_good(8'h75);
        check("ext_break", out, {24'h0, m_out});

        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
        rst_n = 1'b0;
        #1;
        check("midframe_rst_out", out, 32'h0);
        m_out = 8'd0; m_brk = 1'b0; m_ext = 1'b0;
        ps2_data = 1'b1;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(3);
        send_good(8'h45);
        check("after_rst_zero", out, 32'h0030);

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      b = known[$urandom_range(0, known.size() - 1)];
            else if (r < 55) b = 8'hF0;
            else if (r < 65) b = 8'hE0;
            else if (r < 85) b = 8'($urandom_range(0, 255));
            else             b = 8'h1C;
            bp = 1'b0;
            bs = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 1) == 1) bp = 1'b1;
                else bs = 1'b1;
            end
            send_frame(b, bp, bs, lat);
            check($sformatf("rnd%0d_out_%02h", n, b), out, {24'h0, m_out});
            check($sformatf("rnd%0d_err", n), err_pulses, exp_err);
        end
        check("err_width_all", err_long, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_keyboard.md
PS2_KEYBOARD -- requirements
Module: ps2_keyboard

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1600, is the number of clk cycles without a PS/2 clock falling edge after which a partial frame is abandoned (100 us at 16 MHz).
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clk.
REQ-005 ps2_data  input  1  raw PS/2 data pin, asynchronous to clk.
REQ-006 out  output  16  Hack key code of the currently held key, 0 when none; drives the memory-mapped keyboard word at 0x6000.
REQ-007 frame_err  output  1  one-cycle pulse on each rejected frame.

Function
REQ-008 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-009 A PS/2 falling edge SHALL be the synced clock reading 0 after reading 1 for at least 2 consecutive clk cycles (glitch filter).
REQ-010 Receiver FSM states: IDLE, DATA, PARITY, STOP; ps2_data is sampled on each falling edge.
REQ-011 IDLE->DATA on start bit 0; a start bit of 1 stays in IDLE with no error.
REQ-012 DATA shifts in 8 bits LSB first, then goes to PARITY; PARITY->STOP; STOP->IDLE.
REQ-013 A frame is accepted only if parity is odd over data plus parity bit and the stop bit is 1; otherwise it is discarded and frame_err pulses 1 cycle after the stop sample.
REQ-014 In any state except IDLE, TIMEOUT_CYCLES clk cycles without a falling edge SHALL return the FSM to IDLE, discard the partial byte, and leave frame_err low.
REQ-015 Accepted byte 0xF0 sets a break flag; accepted byte 0xE0 sets an extended flag (see REQ-024); neither changes out.
REQ-016 Make (break flag clear): if the mapped code is nonzero, out takes it; unmapped codes leave out unchanged.
REQ-017 Break (break flag set): if the mapped code equals out, out becomes 0; otherwise out is unchanged. Both flags clear after any non-prefix byte.
REQ-018 out SHALL update exactly 1 clk cycle after the stop bit is sampled; latency from the stop-bit falling edge is at most 5 clk cycles including synchronizer and filter.
REQ-019 Mapping, set 2 to Hack: letters map to uppercase ASCII 65-90; digits 48-57; space 32; Enter (0x5A) 128; Backspace (0x66) 129; Esc (0x76) 140; F1-F12 141-152; everything else 0.
REQ-020 out[15:8] SHALL always be 0.
REQ-021 A typematic repeat of the held key rewrites out with the same value, so out shows no glitch.

Reset
REQ-022 While rst_n=0: out=0, frame_err=0, FSM=IDLE, shift register=0, both flags clear, timeout counter=0, synchronizer flops=1 (bus idle).
REQ-023 Reset asserted mid-frame SHALL abandon the frame; after release, the first complete valid frame is decoded normally.

Configuration
REQ-024 Macro PS2_EXTENDED_EN defined: after an E0 prefix, 0x6B/0x75/0x74/0x72 map to 130/131/132/133 (left/up/right/down); 0x6C/0x69/0x7D/0x7A map to 134/135/136/137 (home/end/pgup/pgdn); 0x70 maps to 138 (insert); 0x71 maps to 139 (delete); all other E0 codes map to 0.
REQ-025 Macro undefined: the byte following an E0 prefix, including an E0 F0 xx sequence, SHALL be ignored, and no extended-flag storage is synthesized.

Structure
REQ-026 A shared package holds the Hack key-code constants (KEY_NEWLINE=128 ... KEY_F12=152) and the PS/2 prefix constants 0xE0 and 0xF0.
REQ-027 One combinational sub-module, ps2_keymap (8-bit scan code plus extended flag in, 8-bit Hack code out), holds the lookup; the FSM, filter and timeout stay in ps2_keyboard.

Verification
REQ-028 Frame 0x1C with parity 0 and stop 1 -> out=0x0041 within 5 clk cycles of the stop edge; frame_err stays 0.
REQ-029 With out=0x0041, send F0 then 1C -> out=0x0000; send F0 then 32 (B, not held) -> out stays 0x0041.
REQ-030 Frame 0x1C with parity bit 1 -> frame_err high for exactly 1 cycle; out unchanged.
REQ-031 Send 5 bits, idle for TIMEOUT_CYCLES+10 cycles, then frame 0x5A -> out=0x0080 and frame_err never asserted.
REQ-032 E0 75 -> out=0x0083 with PS2_EXTENDED_EN defined; out unchanged without it.
REQ-033 Assert rst_n after bit 4 of a frame -> out=0 immediately; the next frame 0x45 -> out=0x0030.
